// File: rtl/mem_stage_param_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_param_if
// Description : Bus bundle between the exec stage, the memory stage and
//               Write_Back.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_param_if #(
    parameter int XLEN = 64
);
    logic            valid_in;
    logic            Mem_Read;
    logic            Mem_Write;
    logic [1:0]      size;
    logic            load_unsigned;
    logic [XLEN-1:0] result_receive;
    logic [XLEN-1:0] writeData;
    logic            Zero_receive;
    logic            Branch_receive;
    logic [XLEN-1:0] pcbranch_receive;
    logic            regWrite_receive;
    logic            Mem_to_Reg_receive;

    logic            stall;
    logic            valid_out;
    logic [XLEN-1:0] ReadData;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] pcbranch;
    logic            PC_SRC;
    logic            regWrite;
    logic            Mem_to_Reg;
    logic            misaligned;

    modport master (
        output valid_in, Mem_Read, Mem_Write, size, load_unsigned,
               result_receive, writeData, Zero_receive, Branch_receive,
               pcbranch_receive, regWrite_receive, Mem_to_Reg_receive,
        input  stall, valid_out, ReadData, result, pcbranch,
               PC_SRC, regWrite, Mem_to_Reg, misaligned
    );

    modport slave (
        input  valid_in, Mem_Read, Mem_Write, size, load_unsigned,
               result_receive, writeData, Zero_receive, Branch_receive,
               pcbranch_receive, regWrite_receive, Mem_to_Reg_receive,
        output stall, valid_out, ReadData, result, pcbranch,
               PC_SRC, regWrite, Mem_to_Reg, misaligned
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_param.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_param
// Description : Parametrised data-memory pipeline stage with sized loads and
//               stores, configurable wait states and branch resolution.
//               Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_param #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset,
    mem_stage_param_if.slave  bus
);
    localparam int         c_NB    = XLEN / 8;
    localparam int         c_OFF_W = $clog2(c_NB);
    localparam int         c_IDX_W = $clog2(DEPTH);
    localparam logic [2:0] c_LAT   = 3'(LATENCY);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [2:0]          r_wait_cnt_q, w_wait_cnt_d;
    logic [XLEN-1:0]     r_mem [DEPTH];

    logic                r_valid_out_q, w_valid_out_d;
    logic [XLEN-1:0]     r_read_data_q, w_read_data_d;
    logic [XLEN-1:0]     r_result_q, w_result_d;
    logic [XLEN-1:0]     r_pcbranch_q, w_pcbranch_d;
    logic                r_pc_src_q, w_pc_src_d;
    logic                r_reg_write_q, w_reg_write_d;
    logic                r_mem_to_reg_q, w_mem_to_reg_d;
    logic                r_misaligned_q, w_misaligned_d;

    logic                w_memop, w_is_load, w_is_store, w_mis, w_stall, w_do_write;
    logic [1:0]          w_size;
    logic [3:0]          w_nbytes;
    logic [c_OFF_W-1:0]  w_off_raw, w_off, w_size_mask;
    logic [c_IDX_W-1:0]  w_idx;
    logic [XLEN-1:0]     w_rd_word, w_shift, w_mask, w_bmask, w_load, w_wr_word;
    logic                w_sign;

    always_comb begin
        w_memop     = bus.valid_in & (bus.Mem_Read | bus.Mem_Write);
        w_is_store  = bus.Mem_Write;
        w_is_load   = bus.Mem_Read & ~bus.Mem_Write;
        w_size      = ((XLEN == 32) && (bus.size == 2'b11)) ? 2'b10 : bus.size;
        w_nbytes    = 4'd1 << w_size;
        w_size_mask = c_OFF_W'(w_nbytes - 4'd1);
        w_off_raw   = bus.result_receive[c_OFF_W-1:0];
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        w_mis       = w_memop & ((w_off_raw & w_size_mask) != '0);
        w_off       = w_off_raw;
`else
        w_mis       = 1'b0;
        w_off       = w_off_raw & ~w_size_mask;
`endif
        w_idx       = bus.result_receive[c_OFF_W +: c_IDX_W];
        w_rd_word   = r_mem[w_idx];

        // Field mask of the access width; its top bit doubles as the sign position.
        w_mask      = (w_size == 2'b11) ? '1 : ((XLEN'(1) << {w_nbytes, 3'b000}) - XLEN'(1));
        w_shift     = w_rd_word >> {w_off, 3'b000};
        w_sign      = |(w_shift & (w_mask ^ (w_mask >> 1)));
        w_load      = (w_shift & w_mask) | ((w_sign & ~bus.load_unsigned) ? ~w_mask : '0);

        w_bmask     = w_mask << {w_off, 3'b000};
        w_wr_word   = (w_rd_word & ~w_bmask) | ((bus.writeData << {w_off, 3'b000}) & w_bmask);
    end

    always_comb begin
        w_stall = 1'b0;
        if (!reset && w_memop && !w_mis) begin
            w_stall = (r_state_q == S_IDLE) ? (c_LAT != 3'd0) : (r_wait_cnt_q != c_LAT);
        end
        w_do_write   = w_memop & ~w_stall & ~reset & w_is_store & ~w_mis;
        w_state_d    = w_stall ? S_WAIT : S_IDLE;
        w_wait_cnt_d = w_stall ? (r_wait_cnt_q + 3'd1) : 3'd0;
    end

    always_comb begin
        w_valid_out_d  = bus.valid_in;
        w_read_data_d  = (w_memop & w_is_load & ~w_mis) ? w_load : '0;
        w_result_d     = bus.result_receive;
        w_pcbranch_d   = bus.pcbranch_receive;
        w_pc_src_d     = bus.valid_in & bus.Branch_receive & bus.Zero_receive;
        w_reg_write_d  = bus.regWrite_receive & ~w_mis;
        w_mem_to_reg_d = bus.Mem_to_Reg_receive;
        w_misaligned_d = w_mis;
        // A stalled edge emits a bubble while data outputs keep their last values.
        if (w_stall) begin
            w_valid_out_d  = 1'b0;
            w_read_data_d  = r_read_data_q;
            w_result_d     = r_result_q;
            w_pcbranch_d   = r_pcbranch_q;
            w_pc_src_d     = 1'b0;
            w_reg_write_d  = 1'b0;
            w_mem_to_reg_d = r_mem_to_reg_q;
            w_misaligned_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= S_IDLE;
            r_wait_cnt_q   <= 3'd0;
            r_valid_out_q  <= 1'b0;
            r_read_data_q  <= '0;
            r_result_q     <= '0;
            r_pcbranch_q   <= '0;
            r_pc_src_q     <= 1'b0;
            r_reg_write_q  <= 1'b0;
            r_mem_to_reg_q <= 1'b0;
            r_misaligned_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_wait_cnt_q   <= w_wait_cnt_d;
            r_valid_out_q  <= w_valid_out_d;
            r_read_data_q  <= w_read_data_d;
            r_result_q     <= w_result_d;
            r_pcbranch_q   <= w_pcbranch_d;
            r_pc_src_q     <= w_pc_src_d;
            r_reg_write_q  <= w_reg_write_d;
            r_mem_to_reg_q <= w_mem_to_reg_d;
            r_misaligned_q <= w_misaligned_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    assign bus.stall      = w_stall;
    assign bus.valid_out  = r_valid_out_q;
    assign bus.ReadData   = r_read_data_q;
    assign bus.result     = r_result_q;
    assign bus.pcbranch   = r_pcbranch_q;
    assign bus.PC_SRC     = r_pc_src_q;
    assign bus.regWrite   = r_reg_write_q;
    assign bus.Mem_to_Reg = r_mem_to_reg_q;
    assign bus.misaligned = r_misaligned_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_stage_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_param
// Description : Scoreboard bench for mem_stage_param with a byte-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_param;
    localparam int XLEN    = 64;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int MEMB    = DEPTH * XLEN / 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_param_if #(.XLEN(XLEN)) bus ();

    mem_stage_param #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rd, wr, uns, br, zr, rw, m2r;
        logic [1:0]  size;
        logic [63:0] addr, wdata, pcb;
    } op_t;

    typedef struct {
        logic [63:0] rdata, res, pcb;
        logic        pcsrc, rw, m2r, mis;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mem_m [MEMB];
    int         checks = 0;
    int         passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: byte-addressed memory, address wraps modulo the memory size.
    task automatic model_step(input op_t op, output exp_t e, output int lat);
        int          n;
        int          a;
        logic        mis;
        logic        memop;
        logic [63:0] v;
        n     = 1 << op.size;
        a     = int'(op.addr % 64'(MEMB));
        mis   = 1'b0;
        memop = op.rd | op.wr;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        if (memop && (a % n) != 0) mis = 1'b1;
`else
        a = a - (a % n);
`endif
        e.rdata = '0;
        if (memop && !mis) begin
            if (op.wr) begin
                for (int i = 0; i < n; i++) mem_m[a + i] = op.wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[a + i];
                if (!op.uns && n < 8 && v[8*n-1])
                    for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
                e.rdata = v;
            end
        end
        e.res   = op.addr;
        e.pcb   = op.pcb;
        e.pcsrc = op.br & op.zr;
        e.rw    = op.rw & ~mis;
        e.m2r   = op.m2r;
        e.mis   = mis;
        lat     = (memop && !mis) ? LATENCY : 0;
    endtask

    function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [63:0] addr, input logic [63:0] wdata);
        op_t o;
        o.rd = rd; o.wr = wr; o.size = size; o.uns = uns; o.addr = addr; o.wdata = wdata;
        o.br = 1'b0; o.zr = 1'b0; o.rw = rd; o.m2r = rd; o.pcb = 64'($urandom);
        return o;
    endfunction

    task automatic drive(input op_t op);
        bus.valid_in           = 1'b1;
        bus.Mem_Read           = op.rd;
        bus.Mem_Write          = op.wr;
        bus.size               = op.size;
        bus.load_unsigned      = op.uns;
        bus.result_receive     = op.addr;
        bus.writeData          = op.wdata;
        bus.Zero_receive       = op.zr;
        bus.Branch_receive     = op.br;
        bus.pcbranch_receive   = op.pcb;
        bus.regWrite_receive   = op.rw;
        bus.Mem_to_Reg_receive = op.m2r;
    endtask

    // Entered just after a rising edge; returns just after the access edge.
    task automatic issue(input op_t op);
        exp_t e;
        int   lat;
        int   stalls;
        drive(op);
        model_step(op, e, lat);
        q.push_back(e);
        stalls = 0;
        @(negedge clk);
        while (bus.stall === 1'b1 && stalls < 20) begin
            stalls++;
            @(negedge clk);
            check("bubble_valid_out", 64'(bus.valid_out), 64'd0);
            check("bubble_regWrite", 64'(bus.regWrite), 64'd0);
            check("bubble_PC_SRC", 64'(bus.PC_SRC), 64'd0);
        end
        check("stall_cycles", 64'(stalls), 64'(lat));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid_in  = 1'b0;
        bus.Mem_Read  = 1'b0;
        bus.Mem_Write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero();
        check("rst_valid_out", 64'(bus.valid_out), 64'd0);
        check("rst_ReadData", bus.ReadData, 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_pcbranch", bus.pcbranch, 64'd0);
        check("rst_PC_SRC", 64'(bus.PC_SRC), 64'd0);
        check("rst_regWrite", 64'(bus.regWrite), 64'd0);
        check("rst_Mem_to_Reg", 64'(bus.Mem_to_Reg), 64'd0);
        check("rst_misaligned", 64'(bus.misaligned), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && bus.valid_out === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got result %h expected no output", bus.result);
            end else begin
                e = q.pop_front();
                check("ReadData", bus.ReadData, e.rdata);
                check("result", bus.result, e.res);
                check("pcbranch", bus.pcbranch, e.pcb);
                check("PC_SRC", 64'(bus.PC_SRC), 64'(e.pcsrc));
                check("regWrite", 64'(bus.regWrite), 64'(e.rw));
                check("Mem_to_Reg", 64'(bus.Mem_to_Reg), 64'(e.m2r));
                check("misaligned", 64'(bus.misaligned), 64'(e.mis));
            end
        end
    end

    initial begin
        op_t o;
        reset = 1'b1;
        drive(mk(1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'd0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check_outputs_zero();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        for (int k = 0; k < 16; k++)
            issue(mk(1'b0, 1'b1, 2'b11, 1'b0, 64'(k * 8), {$urandom, $urandom}));

        issue(mk(1'b0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788));
        issue(mk(1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'd0));
        issue(mk(1'b0, 1'b1, 2'b00, 1'b0, 64'h13, 64'hFF));
        issue(mk(1'b1, 1'b0, 2'b00, 1'b0, 64'h13, 64'd0));
        issue(mk(1'b1, 1'b0, 2'b00, 1'b1, 64'h13, 64'd0));
        issue(mk(1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'd0));

        o = mk(1'b0, 1'b0, 2'b00, 1'b0, 64'h40, 64'd0);
        o.br = 1'b1; o.zr = 1'b1; o.pcb = 64'd12; o.rw = 1'b1;
        issue(o);
        o.zr = 1'b0;
        issue(o);

        issue(mk(1'b0, 1'b1, 2'b01, 1'b0, 64'h11, 64'hABCD));
        issue(mk(1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'd0));
        issue(mk(1'b1, 1'b1, 2'b10, 1'b0, 64'h18, 64'h55AA55AA));

        for (int k = 0; k < 150; k++) begin
            int t;
            t = $urandom_range(0, 3);
            o = mk(t == 0 || t == 2, t == 1 || t == 2, 2'($urandom_range(0, 3)), 1'($urandom),
                   64'($urandom_range(0, 127)) | (64'($urandom) << 11), {$urandom, $urandom});
            o.br = 1'($urandom); o.zr = 1'($urandom); o.rw = 1'($urandom); o.m2r = 1'($urandom);
            issue(o);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end

        idle(2);
        check("drain", 64'(q.size()), 64'd0);

        drive(mk(1'b0, 1'b1, 2'b11, 1'b0, 64'h20, 64'hDEADBEEFCAFEF00D));
        @(negedge clk);
        check("abort_stall_before", 64'(bus.stall), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_stall_in_reset", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.valid_in = 1'b0;
        @(negedge clk);
        check_outputs_zero();
        @(posedge clk);
        #1;
        issue(mk(1'b1, 1'b0, 2'b11, 1'b0, 64'h20, 64'd0));

        idle(3);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
